// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: PS/2 frame receiver with make/break key tracking.
// Produces scan code, held flag and press count for display drivers.
module ps2_key_tracker #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       clrn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] scan_code,
   output logic       key_down,
   output logic       ext,
   output logic [7:0] press_count,
   output logic       code_valid,
   output logic       frame_err
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYCLES);

   localparam logic [7:0] PFX_EXT = 8'hE0;
   localparam logic [7:0] PFX_BRK = 8'hF0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXT,
      S_BRK,
      S_EXT_BRK
   } state_t;

   logic [2:0]       clk_sync;
   logic [1:0]       data_sync;
   logic             fe;
   logic             din;

   logic [3:0]       bit_cnt;
   logic [10:0]      shreg;
   logic [CNT_W-1:0] tmo;
   logic             expire;
   logic             last_bit;
   logic [10:0]      frame;
   logic             frame_ok;
   logic             byte_ok;
   logic [7:0]       rx_byte;

   state_t           state;
   state_t           state_nxt;

   logic             is_make;
   logic             is_break;
   logic             code_ext;
   logic             repeat_hit;

   logic [7:0]       scan_nxt;
   logic             ext_nxt;
   logic             down_nxt;
   logic [7:0]       cnt_nxt;
   logic             valid_nxt;

   // Synchronise raw keyboard lines; data tracks clock stages 1-2.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign fe  = (clk_sync[2:1] == 2'b10);
   assign din = data_sync[1];

   assign expire   = (bit_cnt != 4'd0) && (tmo == TMO_MAX);
   assign last_bit = fe && !expire && (bit_cnt == 4'd10);

   // Frame as it will look once the current bit is shifted in.
   assign frame    = {din, shreg[10:1]};
   assign frame_ok = !frame[0] && frame[10] && (^frame[9:1]);
   assign byte_ok  = last_bit && frame_ok;
   assign rx_byte  = frame[8:1];

   // Bit counter and LSB-first shift register; timeout restarts the frame.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         bit_cnt <= 4'd0;
         shreg   <= 11'd0;
      end else if (expire) begin
         bit_cnt <= fe ? 4'd1 : 4'd0;
         if (fe) shreg <= {din, shreg[10:1]};
      end else if (fe) begin
         shreg   <= {din, shreg[10:1]};
         bit_cnt <= (bit_cnt == 4'd10) ? 4'd0 : bit_cnt + 4'd1;
      end
   end

   // Idle-time counter between ps2 clock edges inside a frame.
   always_ff @(posedge clk) begin
      if (!clrn || bit_cnt == 4'd0 || fe || expire)
         tmo <= '0;
      else
         tmo <= tmo + 1'b1;
   end

   // Flag a completed frame that failed start/stop/parity checks.
   always_ff @(posedge clk) begin
      if (!clrn)
         frame_err <= 1'b0;
      else
         frame_err <= last_bit && !frame_ok;
   end

   // Decode FSM state register.
   always_ff @(posedge clk) begin
      if (!clrn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Decode FSM next-state: track E0/F0 prefixes.
   always_comb begin
      state_nxt = state;
      if (byte_ok) begin
         unique case (state)
            S_IDLE: begin
               if (rx_byte == PFX_EXT)
                  state_nxt = S_EXT;
               else if (rx_byte == PFX_BRK)
                  state_nxt = S_BRK;
               else
                  state_nxt = S_IDLE;
            end
            S_EXT: begin
               if (rx_byte == PFX_BRK)
                  state_nxt = S_EXT_BRK;
               else if (rx_byte == PFX_EXT)
                  state_nxt = S_EXT;
               else
                  state_nxt = S_IDLE;
            end
            S_BRK,
            S_EXT_BRK: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
         endcase
      end
   end

   // Classify the accepted byte as make, break or prefix.
   always_comb begin
      is_make  = 1'b0;
      is_break = 1'b0;
      code_ext = 1'b0;
      if (byte_ok) begin
         unique case (state)
            S_IDLE: begin
               is_make = (rx_byte != PFX_EXT) && (rx_byte != PFX_BRK);
            end
            S_EXT: begin
               is_make  = (rx_byte != PFX_EXT) && (rx_byte != PFX_BRK);
               code_ext = 1'b1;
            end
            S_BRK: begin
               is_break = 1'b1;
            end
            S_EXT_BRK: begin
               is_break = 1'b1;
               code_ext = 1'b1;
            end
            default: begin
               is_make  = 1'b0;
               is_break = 1'b0;
            end
         endcase
      end
   end

   assign repeat_hit = key_down && (scan_code == rx_byte) && (ext == code_ext);

   // Next output values: new press, typematic repeat, or release.
   always_comb begin
      scan_nxt  = scan_code;
      ext_nxt   = ext;
      down_nxt  = key_down;
      cnt_nxt   = press_count;
      valid_nxt = is_make || is_break;
      if (is_make && !repeat_hit) begin
         scan_nxt = rx_byte;
         ext_nxt  = code_ext;
         down_nxt = 1'b1;
         cnt_nxt  = press_count + 8'd1;
      end
      if (is_break && (rx_byte == scan_code) && (code_ext == ext))
         down_nxt = 1'b0;
   end

   // Registered outputs.
   always_ff @(posedge clk) begin
      if (!clrn) begin
         scan_code   <= 8'd0;
         ext         <= 1'b0;
         key_down    <= 1'b0;
         press_count <= 8'd0;
         code_valid  <= 1'b0;
      end else begin
         scan_code   <= scan_nxt;
         ext         <= ext_nxt;
         key_down    <= down_nxt;
         press_count <= cnt_nxt;
         code_valid  <= valid_nxt;
      end
   end

endmodule
